dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between the pipeline MEM stage (CPU port) and a debug/loader port (DBG port).
- Lets a host preload or inspect dmem at run time without a separate memory copy.
- Stalls the pipeline when DBG wins the memory.
- Keeps a saturating conflict counter for bring-up and debug.

Parameters:
- ADDR_W, 10, word-address width (1024 x 32-bit words).
- MAX_CPU_STREAK, 4, consecutive contested CPU grants allowed before DBG is forced in.
- CNT_W, 16, width of the conflict counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  MEM stage memory access this cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  32  store data.
- cpu_wstrb  in  4  byte enables for stores.
- cpu_stall  out  1  CPU request not granted; pipeline must hold.
- cpu_rdata  out  32  load data.
- cpu_rvalid  out  1  cpu_rdata valid this cycle.
- dbg_req  in  1  debug access request.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  ADDR_W  word address.
- dbg_wdata  in  32  write data.
- dbg_wstrb  in  4  byte enables.
- dbg_lock  in  1  debug burst; DBG holds priority while asserted.
- dbg_gnt  out  1  DBG request accepted this cycle.
- dbg_rdata  out  32  read data.
- dbg_rvalid  out  1  dbg_rdata valid this cycle.
- mem_en  out  1  memory access enable.
- mem_we  out  4  per-byte write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid one cycle after the read.
- conflict_cnt  out  CNT_W  cycles with both requests high, saturating.

Behaviour:
- Grant is combinational from the current inputs and registered state.
  - dbg_sel = dbg_req & (dbg_lock | ~cpu_req | streak == MAX_CPU_STREAK).
  - cpu_gnt = cpu_req & ~dbg_sel.
  - dbg_gnt = dbg_sel.
  - cpu_stall = cpu_req & ~cpu_gnt.
- Memory mux follows the winner.
  - mem_en = cpu_gnt | dbg_gnt.
  - mem_we = winner_we ? winner_wstrb : 4'b0000.
  - mem_addr and mem_wdata come from the winner; both are 0 when there is no grant.
- Streak counter (registered, width clog2(MAX_CPU_STREAK+1)):
  - Increments when cpu_gnt & dbg_req.
  - Clears when dbg_gnt or ~dbg_req.
  - Never exceeds MAX_CPU_STREAK.
  - Once it reaches MAX_CPU_STREAK, DBG wins the next contested cycle.
- Read return, latency exactly 1 cycle:
  - A registered rd_owner ∈ {NONE, CPU, DBG} is set on a granted read and set to NONE otherwise.
  - Cycle N+1 after a granted read: that port's rvalid = 1 and its rdata = mem_rdata.
  - Writes produce no rvalid.
  - Non-owner rdata is driven to 0.
- Back-to-back accesses: every cycle can carry a new grant. The return of the cycle-N read and the issue of the cycle-N+1 access overlap without a bubble.
- conflict_cnt increments when cpu_req & dbg_req, and holds at 2^CNT_W-1.
- Reset, while rst = 1:
  - All grants, mem_en, mem_we, cpu_stall, rvalids, rdata and conflict_cnt are 0.
  - Streak is 0 and rd_owner is NONE.
  - Requests are ignored.
- Reset mid-operation: a read granted in the cycle before rst rises produces no rvalid.
- Simultaneous events:
  - With no lock and streak < MAX_CPU_STREAK, CPU wins.
  - dbg_lock without dbg_req has no effect.
  - cpu_stall may remain high indefinitely under dbg_lock; this is intended for loader bursts.

Test Plan:
- Load 32'hDEADBEEF into dmem word 5. Release rst, then CPU read addr 5 with dbg_req = 0 → no stall; next cycle cpu_rvalid = 1, cpu_rdata = 32'hDEADBEEF, dbg_rvalid = 0.
- DBG write addr 3, data 32'h12345678, wstrb 4'b0011, CPU idle → dbg_gnt = 1 and mem_we = 4'b0011 that cycle. A later CPU read of word 3 returns the low halfword 16'h5678 updated and the upper halfword unchanged.
- cpu_req and dbg_req held high continuously, MAX_CPU_STREAK = 4 →
  - CPU granted 4 cycles, then DBG 1 cycle with cpu_stall = 1, and the pattern repeats.
  - conflict_cnt increments every cycle.
- dbg_lock = 1 with both requests high for 10 cycles → dbg_gnt = 1 and cpu_stall = 1 for all 10 cycles. CPU is granted the cycle after the lock drops.
- Force conflict_cnt to 16'hFFFE with both requests high → 16'hFFFF on the next cycle, then it holds.
- CPU read granted, then rst = 1 on the following edge → cpu_rvalid = 0; conflict_cnt and streak return to 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and a debug/loader port.
// Grants are combinational in the request cycle; read data returns exactly one cycle after a granted read.
// The CPU is stalled whenever DBG wins; dbg_lock may hold the CPU off for as long as it stays asserted.
module dmem_arbiter #(
  parameter int ADDR_W         = 10,
  parameter int MAX_CPU_STREAK = 4,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  input  logic [3:0]        dbg_wstrb,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_rvalid,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int SW = $clog2(MAX_CPU_STREAK + 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  logic [SW-1:0]    r_streak;
  owner_t           r_owner;
  logic [CNT_W-1:0] r_conflict;

  logic w_dbg_sel;
  logic w_cpu_gnt;
  logic w_both_req;

  // Grant decision: DBG wins on lock, on an idle CPU, or once the CPU has used up its contested streak.
  // Everything is gated by rst so requests are ignored while in reset.
  always_comb begin
    w_both_req = cpu_req & dbg_req;
    w_dbg_sel  = ~rst & dbg_req &
                 (dbg_lock | ~cpu_req | (r_streak == SW'(MAX_CPU_STREAK)));
    w_cpu_gnt  = ~rst & cpu_req & ~w_dbg_sel;
    dbg_gnt    = w_dbg_sel;
    cpu_stall  = ~rst & cpu_req & ~w_cpu_gnt;
  end

  // Memory port follows the winner; address and data are zeroed when nobody is granted.
  always_comb begin
    mem_en    = w_cpu_gnt | w_dbg_sel;
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_gnt) begin
      mem_we    = cpu_we ? cpu_wstrb : 4'b0000;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_dbg_sel) begin
      mem_we    = dbg_we ? dbg_wstrb : 4'b0000;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Contested CPU-win streak: grows while DBG is waiting, resets as soon as DBG wins or stops asking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak <= '0;
    end else if (w_dbg_sel || !dbg_req) begin
      r_streak <= '0;
    end else if (w_cpu_gnt && r_streak != SW'(MAX_CPU_STREAK)) begin
      r_streak <= r_streak + SW'(1);
    end
  end

  // Remember which port issued a read so the returning data is steered to it next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= OWN_NONE;
    end else if (w_cpu_gnt && !cpu_we) begin
      r_owner <= OWN_CPU;
    end else if (w_dbg_sel && !dbg_we) begin
      r_owner <= OWN_DBG;
    end else begin
      r_owner <= OWN_NONE;
    end
  end

  // Read return steering; a read whose return cycle coincides with reset is dropped.
  always_comb begin
    cpu_rvalid = ~rst & (r_owner == OWN_CPU);
    dbg_rvalid = ~rst & (r_owner == OWN_DBG);
    cpu_rdata  = cpu_rvalid ? mem_rdata : 32'h0;
    dbg_rdata  = dbg_rvalid ? mem_rdata : 32'h0;
  end

  // Saturating count of cycles where both ports requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict <= '0;
    end else if (w_both_req && !(&r_conflict)) begin
      r_conflict <= r_conflict + CNT_W'(1);
    end
  end

  // Counter reads as zero for the whole reset window, including the first reset cycle.
  always_comb begin
    conflict_cnt = rst ? '0 : r_conflict;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes per-cycle expectations from a reference model,
// a negedge monitor pops and compares them. A second instance with a 4-bit counter exercises saturation.
// The memory behind the arbiter is a simple one-cycle-latency array driven by the DUT's mem_* outputs.
module tb_dmem_arbiter;

  localparam int AW   = 10;
  localparam int MAXS = 4;

  logic          clk;
  logic          rst;
  logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [31:0]   cpu_wdata, dbg_wdata;
  logic [3:0]    cpu_wstrb, dbg_wstrb;

  logic          cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en;
  logic [31:0]   cpu_rdata, dbg_rdata, mem_wdata;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic [15:0]   conflict_cnt;

  logic          s_cpu_stall, s_cpu_rvalid, s_dbg_gnt, s_dbg_rvalid, s_mem_en;
  logic [31:0]   s_cpu_rdata, s_dbg_rdata, s_mem_wdata;
  logic [3:0]    s_mem_we;
  logic [AW-1:0] s_mem_addr;
  logic [3:0]    s_conflict_cnt;

  dmem_arbiter #(.ADDR_W(AW), .MAX_CPU_STREAK(MAXS), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_wstrb(dbg_wstrb), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .dbg_rvalid(dbg_rvalid), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  dmem_arbiter #(.ADDR_W(AW), .MAX_CPU_STREAK(MAXS), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_stall(s_cpu_stall), .cpu_rdata(s_cpu_rdata), .cpu_rvalid(s_cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_wstrb(dbg_wstrb), .dbg_lock(dbg_lock), .dbg_gnt(s_dbg_gnt), .dbg_rdata(s_dbg_rdata),
    .dbg_rvalid(s_dbg_rvalid), .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(s_conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_val(int i);
    logic [15:0] lo;
    lo = 16'(i);
    if (i == 5) return 32'hDEADBEEF;
    return {lo ^ 16'h5A5A, ~lo};
  endfunction

  // Memory behind the arbiter: one-cycle read latency, byte-strobed writes.
  logic [31:0] env_mem [0:(1<<AW)-1];
  logic        env_init = 1'b0;
  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < (1 << AW); i++) env_mem[i] <= init_val(i);
      env_init <= 1'b1;
    end else if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) env_mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= env_mem[mem_addr];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic        stall, dgnt, en;
    logic [3:0]  we;
    logic [AW-1:0] addr;
    logic [31:0] wdata;
    logic        crv;
    logic [31:0] crd;
    logic        drv;
    logic [31:0] drd;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  int          m_run;     // contested cycles the CPU has won in a row
  int          m_cnt, m_cnt_s;
  int          m_owner;   // 0 none, 1 cpu, 2 dbg
  logic [31:0] m_rdv;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Compute this cycle's expectation from the rules, queue it, then advance the model past the edge.
  task automatic step();
    exp_t e;
    bit cg, dg;
    if (rst) begin
      cg = 0; dg = 0;
    end else begin
      dg = dbg_req && (dbg_lock || !cpu_req || m_run >= MAXS);
      cg = cpu_req && !dg;
    end
    e.stall = !rst && cpu_req && !cg;
    e.dgnt  = dg;
    e.en    = cg || dg;
    e.we    = cg ? (cpu_we ? cpu_wstrb : 4'h0) : dg ? (dbg_we ? dbg_wstrb : 4'h0) : 4'h0;
    e.addr  = cg ? cpu_addr : dg ? dbg_addr : '0;
    e.wdata = cg ? cpu_wdata : dg ? dbg_wdata : 32'h0;
    e.crv   = !rst && m_owner == 1;
    e.crd   = e.crv ? m_rdv : 32'h0;
    e.drv   = !rst && m_owner == 2;
    e.drd   = e.drv ? m_rdv : 32'h0;
    e.cnt   = rst ? 16'h0 : 16'(m_cnt);
    e.cnt_s = rst ? 4'h0 : 4'(m_cnt_s);
    exp_q.push_back(e);

    m_owner = 0;
    if (e.en && e.we == 4'h0 && !(cg ? cpu_we : dbg_we)) begin
      m_owner = cg ? 1 : 2;
      m_rdv   = ref_mem[e.addr];
    end
    if (e.en)
      for (int b = 0; b < 4; b++)
        if (e.we[b]) ref_mem[e.addr][b*8 +: 8] = e.wdata[b*8 +: 8];
    if (rst) begin
      m_run = 0; m_cnt = 0; m_cnt_s = 0;
    end else begin
      m_run = (cg && dbg_req) ? m_run + 1 : 0;
      if (cpu_req && dbg_req) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 15) m_cnt_s++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("cpu_stall",    32'(cpu_stall),    32'(e.stall));
      chk("dbg_gnt",      32'(dbg_gnt),      32'(e.dgnt));
      chk("mem_en",       32'(mem_en),       32'(e.en));
      chk("mem_we",       32'(mem_we),       32'(e.we));
      chk("mem_addr",     32'(mem_addr),     32'(e.addr));
      chk("mem_wdata",    mem_wdata,         e.wdata);
      chk("cpu_rvalid",   32'(cpu_rvalid),   32'(e.crv));
      chk("cpu_rdata",    cpu_rdata,         e.crd);
      chk("dbg_rvalid",   32'(dbg_rvalid),   32'(e.drv));
      chk("dbg_rdata",    dbg_rdata,         e.drd);
      chk("conflict_cnt", 32'(conflict_cnt), 32'(e.cnt));
      chk("conflict_sat", 32'(s_conflict_cnt), 32'(e.cnt_s));
    end
  end

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = 4'h0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_wstrb = 4'h0; dbg_lock = 0;
  endtask

  task automatic both_hi(input int n, input bit lock);
    for (int i = 0; i < n; i++) begin
      cpu_req = 1; cpu_we = 0; cpu_addr = AW'(i);
      dbg_req = 1; dbg_we = 0; dbg_addr = AW'(i + 100); dbg_lock = lock;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
    m_run = 0; m_cnt = 0; m_cnt_s = 0; m_owner = 0; m_rdv = '0;
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    // Requests during reset are ignored.
    cpu_req = 1; dbg_req = 1; dbg_lock = 1;
    repeat (3) step();
    idle();
    rst = 0;
    step();

    // CPU read of preloaded word 5, DBG idle.
    cpu_req = 1; cpu_addr = 10'd5;
    step();
    idle();
    step();

    // DBG partial write to word 3, then CPU reads it back.
    dbg_req = 1; dbg_we = 1; dbg_addr = 10'd3; dbg_wdata = 32'h12345678; dbg_wstrb = 4'b0011;
    step();
    idle();
    cpu_req = 1; cpu_addr = 10'd3;
    step();
    idle();
    step();

    // Sustained contention: CPU x4, DBG x1, repeating; small counter saturates.
    both_hi(22, 0);
    // Locked DBG burst, then release.
    both_hi(10, 1);
    both_hi(3, 0);
    idle();
    step();

    // CPU read immediately followed by reset: the return must be dropped.
    cpu_req = 1; cpu_addr = 10'd7;
    step();
    idle();
    rst = 1;
    repeat (2) step();
    rst = 0;
    step();

    // Randomized traffic with occasional lock bursts and resets.
    for (int c = 0; c < 2000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      cpu_req   = ($urandom_range(0, 9) < 7);
      cpu_we    = $urandom_range(0, 1) == 1;
      cpu_addr  = AW'($urandom_range(0, 15));
      cpu_wdata = $urandom;
      cpu_wstrb = 4'($urandom_range(0, 15));
      dbg_req   = ($urandom_range(0, 9) < 5);
      dbg_we    = $urandom_range(0, 1) == 1;
      dbg_addr  = AW'($urandom_range(0, 15));
      dbg_wdata = $urandom;
      dbg_wstrb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) dbg_lock = ~dbg_lock;
      step();
    end
    idle();
    step();

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
